// File: rtl/video_rect_fill_pkg.sv
// Shared definitions for the rectangle fill engine: FSM states, framebuffer
// geometry defaults, palette constants and the corner saturation helper.
package video_rect_fill_pkg;

  localparam int FB_WIDTH_DEF  = 400;
  localparam int FB_HEIGHT_DEF = 240;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_SETUP = 2'd1,
    RF_FILL  = 2'd2,
    RF_DONE  = 2'd3
  } rf_state_t;

  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
  } rect_t;

  function automatic logic [15:0] sat_coord(input logic [15:0] v, input logic [15:0] lim);
    return (v >= lim) ? lim - 16'd1 : v;
  endfunction

endpackage

// File: rtl/rect_addr_gen.sv
// Column/row/address walker over a normalised rectangle; load takes effect next cycle.
// Advance steps one pixel, wrapping to the next row with a precomputed stride; holds otherwise.
module rect_addr_gen #(
  parameter int FB_WIDTH = 400,
  parameter int ADDR_W   = 19
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              advance,
  input  logic [15:0]       xl,
  input  logic [15:0]       xr,
  input  logic [15:0]       yt,
  input  logic [15:0]       yb,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [15:0]       col, row, xl_q, xr_q, yb_q;
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      xl_q     <= '0;
      xr_q     <= '0;
      yb_q     <= '0;
      stride_q <= '0;
    end else if (load) begin
      col      <= xl;
      row      <= yt;
      addr     <= start_addr;
      xl_q     <= xl;
      xr_q     <= xr;
      yb_q     <= yb;
      // Distance from (xr,row) to (xl,row+1), so the row wrap is a single add.
      stride_q <= ADDR_W'(FB_WIDTH) - ADDR_W'(xr - xl);
    end else if (advance) begin
      if (col < xr_q) begin
        col  <= col + 16'd1;
        addr <= addr + ADDR_W'(1);
      end else begin
        col  <= xl_q;
        row  <= row + 16'd1;
        addr <= addr + stride_q;
      end
    end
  end

  assign last = (col == xr_q) && (row == yb_q);

endmodule

// File: rtl/video_rect_fill.sv
// Rectangle fill engine: one framebuffer pixel write per cycle; first write 2 cycles after start.
// iStall high suppresses the write and freezes the walker; outputs are registered.
module video_rect_fill
  import video_rect_fill_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int ADDR_W    = 19,
  parameter int COLOR_W   = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [15:0]        iX0,
  input  logic [15:0]        iY0,
  input  logic [15:0]        iX1,
  input  logic [15:0]        iY1,
  input  logic [COLOR_W-1:0] iColor,
  input  logic               iStall,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [COLOR_W-1:0] oDataOut,
  output logic               oBusy,
  output logic               oDone
);

  rf_state_t          state, state_nxt;
  rect_t              rect_q;
  logic [COLOR_W-1:0] color_q;
  logic [15:0]        xl, xr, yt, yb;
  logic [ADDR_W-1:0]  start_addr, gen_addr;
  logic               gen_last;
  logic               latch, load, advance, we_nxt, busy_nxt, done_nxt;

  // Row base as a constant shift-and-add over the set bits of FB_WIDTH (400 -> <<8, <<7, <<4).
  function automatic logic [ADDR_W-1:0] row_base(input logic [15:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 16; b++) begin
      if (FB_WIDTH[b]) acc = acc + (ADDR_W'(row) << b);
    end
    return acc;
  endfunction

  assign xl = sat_coord((rect_q.x0 < rect_q.x1) ? rect_q.x0 : rect_q.x1, 16'(FB_WIDTH));
  assign xr = sat_coord((rect_q.x0 < rect_q.x1) ? rect_q.x1 : rect_q.x0, 16'(FB_WIDTH));
  assign yt = sat_coord((rect_q.y0 < rect_q.y1) ? rect_q.y0 : rect_q.y1, 16'(FB_HEIGHT));
  assign yb = sat_coord((rect_q.y0 < rect_q.y1) ? rect_q.y1 : rect_q.y0, 16'(FB_HEIGHT));
  assign start_addr = row_base(yt) + ADDR_W'(xl);

  always_ff @(posedge Clock) begin
    if (Reset) state <= RF_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      RF_IDLE: begin
        if (iStart) begin
          latch     = 1'b1;
          state_nxt = RF_SETUP;
        end
      end
      RF_SETUP: begin
        load      = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = RF_FILL;
      end
      RF_FILL: begin
        busy_nxt = 1'b1;
        if (!iStall) begin
          we_nxt = 1'b1;
          if (gen_last) state_nxt = RF_DONE;
          else          advance   = 1'b1;
        end
      end
      RF_DONE: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = RF_IDLE;
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rect_q  <= '0;
      color_q <= '0;
    end else if (latch) begin
      rect_q  <= '{x0: iX0, y0: iY0, x1: iX1, y1: iY1};
      color_q <= iColor;
    end
  end

  rect_addr_gen #(
    .FB_WIDTH(FB_WIDTH),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (load),
    .advance   (advance),
    .xl        (xl),
    .xr        (xr),
    .yt        (yt),
    .yb        (yb),
    .start_addr(start_addr),
    .addr      (gen_addr),
    .last      (gen_last)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oDataOut      <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
    end else begin
      oWriteEnable <= we_nxt;
      oBusy        <= busy_nxt;
      oDone        <= done_nxt;
      if (we_nxt) begin
        oWriteAddress <= gen_addr;
        oDataOut      <= color_q;
      end
    end
  end

endmodule

// File: tb/tb_video_rect_fill.sv
// Bench for video_rect_fill: vector table, hand-built corner sequences and random
// rectangles with random stalls, all checked against a nested-loop pixel model.
module tb_video_rect_fill;
  import video_rect_fill_pkg::*;

  localparam int FB_W = 400;
  localparam int FB_H = 240;

  logic        Clock = 1'b0;
  logic        Reset, iStart, iStall;
  logic [15:0] iX0, iY0, iX1, iY1;
  logic [2:0]  iColor;
  logic        oWriteEnable, oBusy, oDone;
  logic [18:0] oWriteAddress;
  logic [2:0]  oDataOut;

  always #5 Clock = ~Clock;

  video_rect_fill #(
    .FB_WIDTH (FB_W),
    .FB_HEIGHT(FB_H),
    .ADDR_W   (19),
    .COLOR_W  (3)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (iStart),
    .iX0          (iX0),
    .iY0          (iY0),
    .iX1          (iX1),
    .iY1          (iY1),
    .iColor       (iColor),
    .iStall       (iStall),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oDataOut     (oDataOut),
    .oBusy        (oBusy),
    .oDone        (oDone)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int x0, y0, x1, y1, col;
    int n, first_addr, last_addr;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  got_q[$];
  bit   stall_hist[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   first_cyc, done_cyc, done_cnt, busy_cnt, stall_viol, fill_go;
  bit   timed_out;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic int clipv(input int v, input int lim);
    return (v >= lim) ? lim - 1 : v;
  endfunction

  // Expected write stream: every clipped pixel, row-major from the top-left corner.
  function automatic void build_model(input int x0, input int y0, input int x1, input int y1, input int col);
    int xl, xr, yt, yb;
    exp_q.delete();
    xl = clipv((x0 < x1) ? x0 : x1, FB_W);
    xr = clipv((x0 < x1) ? x1 : x0, FB_W);
    yt = clipv((y0 < y1) ? y0 : y1, FB_H);
    yb = clipv((y0 < y1) ? y1 : y0, FB_H);
    for (int r = yt; r <= yb; r++)
      for (int c = xl; c <= xr; c++)
        exp_q.push_back('{r * FB_W + c, col});
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Cycle i drives the inputs sampled on edge i (edge 0 carries iStart) and
  // observes the outputs registered on that edge.
  task automatic run_rect(input int x0, input int y0, input int x1, input int y1, input int col,
                          input int stall_pct, input logic [63:0] stall_mask, input int restart_at);
    int  budget;
    bit  st;
    got_q.delete();
    stall_hist.delete();
    first_cyc = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    stall_viol = 0; fill_go = 0; timed_out = 0;
    build_model(x0, y0, x1, y1, col);
    budget = 3 * exp_q.size() + 60;
    for (int i = 0; ; i++) begin
      if (i == 0) begin
        iX0 = 16'(x0); iY0 = 16'(y0); iX1 = 16'(x1); iY1 = 16'(y1); iColor = 3'(col);
      end else if (i == restart_at) begin
        iX0 = 16'd100; iY0 = 16'd100; iX1 = 16'd101; iY1 = 16'd101; iColor = ~3'(col);
      end
      iStart = (i == 0) || (i == restart_at);
      st = (i < 64 && stall_mask[i]) || (stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
      iStall = st;
      stall_hist.push_back(st);
      step();
      if (oWriteEnable) begin
        got_q.push_back('{int'(oWriteAddress), int'(oDataOut)});
        if (first_cyc < 0) first_cyc = i;
        if (st) stall_viol++;
      end
      if (oDone) begin
        done_cnt++;
        done_cyc = i;
      end
      if (oBusy) busy_cnt++;
      if (done_cyc >= 0 && i >= done_cyc + 4) break;
      if (i > budget) begin
        timed_out = 1;
        break;
      end
    end
    iStart = 1'b0;
    iStall = 1'b0;
    for (int i = 2; i < done_cyc; i++) if (!stall_hist[i]) fill_go++;
  endtask

  task automatic verify(input string name, input bit timing);
    int bad, n;
    bad = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      if (got_q[k].addr != exp_q[k].addr || got_q[k].data != exp_q[k].data) bad++;
    check({name, " timeout"}, 32'(timed_out), 0);
    check({name, " write count"}, got_q.size(), exp_q.size());
    check({name, " write stream mismatches"}, bad, 0);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " write while stalled"}, stall_viol, 0);
    check({name, " unstalled fill cycles"}, fill_go, exp_q.size());
    check({name, " busy cycles"}, busy_cnt, done_cyc);
    if (timing) begin
      check({name, " first write cycle"}, first_cyc, 2);
      check({name, " done cycle"}, done_cyc, exp_q.size() + 2);
    end
  endtask

  initial begin
    int writes, busy_seen, a, b, c, d;

    vecs[0] = '{10, 5, 12, 6, COLOR_GREEN, 6, 2010, 2412};
    vecs[1] = '{500, 300, 398, 238, COLOR_MAGENTA, 4, 95598, 95999};
    vecs[2] = '{0, 0, 0, 0, COLOR_WHITE, 1, 0, 0};
    vecs[3] = '{399, 239, 0, 239, COLOR_BLUE, 400, 95600, 95999};
    vecs[4] = '{7, 239, 7, 0, COLOR_RED, 240, 7, 95607};
    vecs[5] = '{65535, 65535, 65535, 0, COLOR_YELLOW, 240, 399, 95999};
    vecs[6] = '{3, 2, 5, 2, COLOR_CYAN, 3, 803, 805};

    Reset = 1'b1; iStart = 1'b0; iStall = 1'b0;
    iX0 = '0; iY0 = '0; iX1 = '0; iY1 = '0; iColor = '0;
    step();
    step();
    check("reset we", 32'(oWriteEnable), 0);
    check("reset addr", 32'(oWriteAddress), 0);
    check("reset data", 32'(oDataOut), 0);
    check("reset busy", 32'(oBusy), 0);
    check("reset done", 32'(oDone), 0);
    Reset = 1'b0;
    step();

    foreach (vecs[v]) begin
      run_rect(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].col, 0, 64'd0, -1);
      verify($sformatf("vec%0d", v), 1'b1);
      check($sformatf("vec%0d n", v), got_q.size(), vecs[v].n);
      check($sformatf("vec%0d first addr", v), (got_q.size() > 0) ? got_q[0].addr : -1, vecs[v].first_addr);
      check($sformatf("vec%0d last addr", v), (got_q.size() > 0) ? got_q[got_q.size()-1].addr : -1, vecs[v].last_addr);
    end

    // Stall on the 2nd and 3rd FILL cycles (edges 3 and 4): writes 0..3, done on edge 8.
    run_rect(0, 0, 3, 0, 5, 0, 64'h18, -1);
    verify("stall", 1'b0);
    check("stall first write cycle", first_cyc, 2);
    check("stall done cycle", done_cyc, 8);

    // Reset sampled on the edge after the 3rd write becomes visible.
    iX0 = 16'd0; iY0 = 16'd0; iX1 = 16'd9; iY1 = 16'd9; iColor = 3'd6;
    writes = 0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      iStart = (i == 0);
      Reset  = (i == 5);
      step();
      if (oWriteEnable) writes++;
    end
    Reset = 1'b0;
    check("midreset we", 32'(oWriteEnable), 0);
    check("midreset addr", 32'(oWriteAddress), 0);
    check("midreset data", 32'(oDataOut), 0);
    check("midreset busy", 32'(oBusy), 0);
    check("midreset done", 32'(oDone), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (oWriteEnable) writes++;
      if (oBusy || oDone) busy_seen++;
    end
    check("midreset writes", writes, 3);
    check("midreset activity after reset", busy_seen, 0);
    run_rect(vecs[0].x0, vecs[0].y0, vecs[0].x1, vecs[0].y1, vecs[0].col, 0, 64'd0, -1);
    verify("after reset", 1'b1);

    // A second start during FILL must be dropped entirely.
    run_rect(0, 0, 3, 1, 3, 0, 64'd0, 4);
    verify("start while busy", 1'b1);
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (oWriteEnable || oBusy) writes++;
    end
    check("start while busy trailing activity", writes, 0);

    for (int t = 0; t < 30; t++) begin
      a = $urandom_range(0, 420);
      b = a + $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(400, 65535);
        b = a - $urandom_range(0, 15);
      end
      c = $urandom_range(0, 250);
      d = c + $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        int tmp;
        tmp = a; a = b; b = tmp;
      end
      if ($urandom_range(0, 1) == 1) begin
        int tmp;
        tmp = c; c = d; d = tmp;
      end
      run_rect(a, c, b, d, $urandom_range(0, 7), 25, 64'd0, -1);
      verify($sformatf("rand%0d", t), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_rect_fill.md
Name: video_rect_fill

Overview:
- Write-side engine for the 400x240 3-bit video framebuffer; the display scan-out path is the read side of the same memory.
- Accepts a rectangle and a colour from the MiniAlu core over a start/busy/done handshake.
- Writes every pixel of the rectangle into the framebuffer write port, one pixel per cycle.
- Frees the CPU from per-pixel STO/address arithmetic.

Parameters:
- FB_WIDTH, 400, framebuffer columns; also the row stride in addresses.
- FB_HEIGHT, 240, framebuffer rows.
- ADDR_W, 19, framebuffer address width.
- COLOR_W, 3, pixel width {R,G,B}.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- iStart  in  1  single-cycle request; sampled only in IDLE.
- iX0  in  16  corner A column.
- iY0  in  16  corner A row.
- iX1  in  16  corner B column.
- iY1  in  16  corner B row.
- iColor  in  COLOR_W  fill colour.
- iStall  in  1  backpressure; while high, no write and no advance.
- oWriteEnable  out  1  framebuffer write strobe.
- oWriteAddress  out  ADDR_W  framebuffer address = FB_WIDTH*row + col.
- oDataOut  out  COLOR_W  pixel data.
- oBusy  out  1  high from the cycle after an accepted start through the DONE state.
- oDone  out  1  one-cycle pulse when the last pixel has been written.

Behaviour:
- Reset (Clock edge with Reset=1) sets all outputs to 0 and the state to IDLE. Applies from any state; an in-progress fill is abandoned and no further writes occur.
- States: IDLE -> SETUP -> FILL -> DONE -> IDLE.
- IDLE
  - iStart=1 latches iX0/iY0/iX1/iY1/iColor and goes to SETUP.
  - iStart in any other state is ignored and not queued.
- SETUP (1 cycle)
  - Normalise corners: xl=min(x0,x1), xr=max(x0,x1), yt=min(y0,y1), yb=max(y0,y1).
  - Clip: any value >= FB_WIDTH saturates to FB_WIDTH-1; any row >= FB_HEIGHT saturates to FB_HEIGHT-1. Clipping happens after normalisation.
  - Start address = yt*400 + xl, computed as (yt<<8)+(yt<<7)+(yt<<4)+xl. No multiplier instance.
- FILL
  - Each cycle with iStall=0: oWriteEnable=1, oWriteAddress=current address, oDataOut=colour.
  - Advance: if col<xr then col+1, addr+1. Otherwise col=xl, row+1, addr += FB_WIDTH-(xr-xl).
  - After writing (xr,yb), go to DONE.
  - iStall=1: oWriteEnable=0, and col/row/addr hold.
- Outputs are registered. First write strobe appears 2 cycles after the iStart edge. With no stall the fill takes exactly (xr-xl+1)*(yb-yt+1) write cycles.
- DONE (1 cycle): oDone=1, oBusy=1, oWriteEnable=0; next state IDLE.
- Degenerate cases:
  - Single pixel (xl=xr, yt=yb): exactly one write.
  - Single row or single column behaves correctly with no off-by-one.
- Address never exceeds FB_WIDTH*FB_HEIGHT-1 = 95999.
- Counters sized for 16-bit inputs; no wrap.

Decomposition:
- Shared Defintions.v include: state encodings (RF_IDLE, RF_SETUP, RF_FILL, RF_DONE), FB_WIDTH/FB_HEIGHT defaults, and existing COLOR_* constants.
- One natural sub-module: rect_addr_gen, holding the col/row/addr counters and the row-wrap stride add. It is driven by an advance/load pair from the FSM in the top module.

Test Plan:
- Normal fill: Start with (10,5)-(12,6), colour 3'b010, no stall -> 6 writes at addresses 2010,2011,2012,2410,2411,2412. First write 2 cycles after start. oDone pulses 1 cycle after the last write.
- Swapped corners and clipping: (500,300)-(398,238) -> normalised to (398,238)-(399,239). 4 writes at 95598,95599,95998,95999.
- Single pixel: (0,0)-(0,0) colour 3'b111 -> exactly one write at address 0 with data 7. oBusy high for SETUP, FILL and DONE (3 cycles).
- Stall: fill (0,0)-(3,0) with iStall high on the 2nd and 3rd FILL cycles -> write strobes at addresses 0,1,2,3 with no skips or duplicates. Total FILL duration 6 cycles.
- Reset mid-fill: assert Reset during the 3rd write of (0,0)-(9,9) -> next cycle all outputs 0, state IDLE, no further writes. A subsequent start works normally.
- Start while busy: a second iStart pulse during FILL -> ignored. Only the first rectangle is written and there is exactly one oDone pulse.
